// File: rtl/dualmem_pkg.sv
// Shared widths and the response record for the dualmem port front-end.
package dualmem_pkg;

  localparam int DUALMEM_ADDR_W = 11;
  localparam int DUALMEM_DATA_W = 64;
  localparam int DUALMEM_BE_W   = 8;

  typedef struct packed {
    logic                      write;
    logic [DUALMEM_DATA_W-1:0] rdata;
  } dualmem_rsp_t;

endpackage

// File: rtl/dualmem_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; no bypass, head read straight from storage.
module dualmem_rsp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = storage[rd_ptr];

  // NOTE: storage has no reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= din;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dualmem_port_ctrl.sv
// Request/response front-end for one port of the byte-enabled dual-port memory.
module dualmem_port_ctrl
  import dualmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DUALMEM_ADDR_W,
  parameter int DATA_WIDTH = DUALMEM_DATA_W,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  output logic [DATA_WIDTH/8-1:0] mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic                  fire, rsp_pop;
  logic                  inflight, inflight_write;
  logic [CNT_W-1:0]      count, occupancy;
  logic                  rsp_empty, rsp_full;
  logic [DATA_WIDTH:0]   push_data, head;

  assign fire      = req_valid && req_ready;
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign occupancy = count + CNT_W'(inflight);

  // A slot freed by this cycle's pop may be reused, hence the rsp_ready -> req_ready path.
  assign req_ready = !rst && ((!rsp_full && occupancy != DEPTH_C) ||
                              (occupancy == DEPTH_C && rsp_pop));

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_en   = '0;
    mem_we   = '0;
    if (!rst) begin
      mem_addr = req_addr;
      mem_din  = req_wdata;
    end
    if (fire) begin
      if (req_we) begin
        mem_en = req_be;
        mem_we = req_be;
      end else begin
        mem_en = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight       <= 1'b0;
      inflight_write <= 1'b0;
    end else begin
      inflight       <= fire;
      inflight_write <= req_we;
    end
  end

  // Memory read data is valid one cycle after enable, so capture it then.
  assign push_data = {inflight_write, inflight_write ? '0 : mem_dout};

  dualmem_rsp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (rsp_pop),
    .din   (push_data),
    .dout  (head),
    .count (count),
    .empty (rsp_empty),
    .full  (rsp_full)
  );

  assign rsp_write = rsp_empty ? 1'b0 : head[DATA_WIDTH];
  assign rsp_rdata = rsp_empty ? '0   : head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dualmem_port_ctrl.sv
// Directed bench for dualmem_port_ctrl with a behavioural memory and an in-order scoreboard.
module tb_dualmem_port_ctrl;
  import dualmem_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [10:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [63:0] rsp_rdata;
  logic [10:0] mem_addr;
  logic [63:0] mem_din, mem_dout;
  logic [7:0]  mem_en, mem_we;

  int tests = 0;
  int fails = 0;

  dualmem_port_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(64), .RSP_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural byte-lane memory, one cycle read latency.
  logic [63:0] mem_model [2048];
  logic [63:0] dout_q;
  assign mem_dout = dout_q;
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (mem_en[b]) begin
        if (mem_we[b]) mem_model[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
        else           dout_q[b*8 +: 8]             <= mem_model[mem_addr][b*8 +: 8];
      end
    end
  end

  logic [63:0]  shadow [2048];
  dualmem_rsp_t exp_q [$];
  int           run_len = 0;
  int           max_run = 0;
  int           waited = 0;
  logic [7:0]   last_mem_en, last_mem_we;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) run_len++;
    else           run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (rsp_valid && rsp_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check("rsp_without_req", 64'(exp_q.size()), 64'd1);
      end else begin
        dualmem_rsp_t e;
        e = exp_q.pop_front();
        check("rsp_write", {63'b0, rsp_write}, {63'b0, e.write});
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
  endtask

  task automatic push_expect(input logic we, input logic [10:0] addr,
                             input logic [63:0] data, input logic [7:0] be);
    dualmem_rsp_t e;
    if (we) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) shadow[addr][b*8 +: 8] = data[b*8 +: 8];
      e.write = 1'b1;
      e.rdata = '0;
    end else begin
      e.write = 1'b0;
      e.rdata = shadow[addr];
    end
    exp_q.push_back(e);
  endtask

  // Holds the request until accepted; leaves req_valid high for back-to-back use.
  task automatic do_req(input logic we, input logic [10:0] addr,
                        input logic [63:0] data, input logic [7:0] be);
    int w;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_be    = be;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    waited += w;
    if (!req_ready) begin
      check("req_accept_timeout", {63'b0, req_ready}, 64'd1);
    end else begin
      last_mem_en = mem_en;
      last_mem_we = mem_we;
      push_expect(we, addr, data, be);
    end
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 30) begin
      n++;
      @(negedge clk);
    end
    step();
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rd_addrs [6];
    logic [63:0] head_a;
    int          accepted;

    for (int i = 0; i < 2048; i++) begin
      mem_model[i] = '0;
      shadow[i]    = '0;
    end
    dout_q = '0;

    // Reset with an active request on the inputs: everything must stay quiet.
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 11'h123;
    req_wdata = '1;
    req_be    = '1;
    rsp_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("rst_req_ready", {63'b0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_mem_en",    {56'b0, mem_en},    64'd0);
    check("rst_mem_we",    {56'b0, mem_we},    64'd0);
    check("rst_mem_addr",  {53'b0, mem_addr},  64'd0);
    check("rst_mem_din",   mem_din,            64'd0);
    check("rst_rsp_rdata", rsp_rdata,          64'd0);
    step();
    rst = 1'b0;
    idle();
    step();

    // Full write then read-after-write to the same address.
    do_req(1'b1, 11'h005, 64'h1122334455667788, 8'hFF);
    do_req(1'b0, 11'h005, '0, '0);
    idle();
    drain();

    // Isolated read: response visible two cycles after the fire cycle.
    do_req(1'b0, 11'h005, '0, '0);
    idle();
    @(negedge clk);
    check("lat_t1_no_rsp", {63'b0, rsp_valid}, 64'd0);
    @(negedge clk);
    check("lat_t2_rsp", {63'b0, rsp_valid}, 64'd1);
    drain();

    // Partial write over zeros.
    do_req(1'b1, 11'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    check("partial_mem_we", {56'b0, last_mem_we}, 64'h0F);
    check("partial_mem_en", {56'b0, last_mem_en}, 64'h0F);
    do_req(1'b0, 11'h010, '0, '0);
    idle();
    drain();

    // Address extremes, then back-to-back reads at full rate.
    do_req(1'b1, 11'h7FF, 64'hDEADBEEF0BADF00D, 8'hFF);
    do_req(1'b1, 11'h000, 64'h0123456789ABCDEF, 8'hFF);
    do_req(1'b1, 11'h400, 64'hFEDCBA9876543210, 8'hFF);
    idle();
    drain();
    max_run = 0;
    waited  = 0;
    do_req(1'b0, 11'h7FF, '0, '0);
    do_req(1'b0, 11'h000, '0, '0);
    do_req(1'b0, 11'h400, '0, '0);
    idle();
    drain();
    check("b2b_ready_stalls", 64'(waited), 64'd0);
    check("b2b_rsp_run", 64'(max_run), 64'd3);

    // Backpressure: only RSP_DEPTH reads are accepted, head stays put.
    rd_addrs[0] = 11'h005; rd_addrs[1] = 11'h010; rd_addrs[2] = 11'h7FF;
    rd_addrs[3] = 11'h000; rd_addrs[4] = 11'h400; rd_addrs[5] = 11'h005;
    rsp_ready = 1'b0;
    accepted  = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_addr = rd_addrs[accepted];
      @(negedge clk);
      if (req_ready) begin
        push_expect(1'b0, rd_addrs[accepted], '0, '0);
        accepted++;
      end
      step();
    end
    check("bp_accepted", 64'(accepted), 64'd2);
    @(negedge clk);
    check("bp_ready_low", {63'b0, req_ready}, 64'd0);
    head_a = rsp_rdata;
    repeat (3) @(negedge clk);
    check("bp_head_stable", rsp_rdata, head_a);
    check("bp_head_value", rsp_rdata, shadow[11'h005]);
    step();
    idle();
    rsp_ready = 1'b1;
    drain();

    // Zero byte-enable write: acknowledged, memory untouched.
    do_req(1'b1, 11'h7FF, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    check("be0_mem_en", {56'b0, last_mem_en}, 64'd0);
    check("be0_mem_we", {56'b0, last_mem_we}, 64'd0);
    do_req(1'b0, 11'h7FF, '0, '0);
    idle();
    drain();

    // Reset with one response queued and one read in flight.
    rsp_ready = 1'b0;
    do_req(1'b0, 11'h005, '0, '0);
    do_req(1'b0, 11'h010, '0, '0);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 11'h400;
    @(negedge clk);
    check("midrst_req_ready", {63'b0, req_ready}, 64'd0);
    check("midrst_mem_en", {56'b0, mem_en}, 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    idle();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("postrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("postrst_rsp_write", {63'b0, rsp_write}, 64'd0);
    check("postrst_rsp_rdata", rsp_rdata, 64'd0);
    check("postrst_req_ready", {63'b0, req_ready}, 64'd1);
    repeat (4) @(negedge clk);
    check("postrst_no_stale", {63'b0, rsp_valid}, 64'd0);

    // Port still works after the mid-transfer reset.
    step();
    do_req(1'b0, 11'h000, '0, '0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
